// File: rtl/polarity_pipe_pkg.sv
// polarity_pipe_pkg
//   Shared constants for the polarity pipeline: legal ranges for the data
//   width and pipeline depth, and the helper that sizes the occupancy count.
//   Imported by polarity_stage and polarity_pipe.
package polarity_pipe_pkg;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;
  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 8;

  // Bits needed to hold a count from 0 up to and including depth.
  function automatic int cnt_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/polarity_stage.sv
// polarity_stage
//   One pipeline stage: a single WIDTH+1-bit register holding {valid, data}.
//   Asynchronous active-low reset clears it; flush clears it on the next edge
//   and wins over en; en=1 loads the input pair, en=0 holds.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   en       in   load enable
//   flush    in   synchronous clear (priority over en)
//   d_valid  in   valid flag from the previous stage
//   d_data   in   WIDTH data from the previous stage
//   q_valid  out  registered valid flag
//   q_data   out  registered WIDTH data
module polarity_stage
  import polarity_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_data,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_data
);

  // Valid lives in the MSB so the stage is one register word.
  logic [WIDTH:0] stage_q;

  // Data is not gated by valid: an invalid slot still shifts its payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else if (flush) begin
      stage_q <= '0;
    end else if (en) begin
      stage_q <= {d_valid, d_data};
    end
  end

  assign q_valid = stage_q[WIDTH];
  assign q_data  = stage_q[WIDTH-1:0];

endmodule

// File: rtl/polarity_pipe.sv
// polarity_pipe
//   DEPTH-stage register pipeline that applies a per-bit polarity inversion
//   (in_data XOR inv_mask) on entry to stage 0 and carries a valid flag per
//   stage. The whole pipe advances when en=1, holds when en=0, and is cleared
//   by flush (synchronous) or rst_n (asynchronous). A running occupancy count
//   tracks how many stages hold valid data.
//
// Parameters
//   WIDTH  data width, 1..64
//   DEPTH  number of register stages (latency in enabled cycles), 1..8
//   CNT_W  occupancy width, default enough bits to count 0..DEPTH
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   en         in   advance enable
//   flush      in   synchronous clear of all stages and the count
//   in_valid   in   qualifies in_data
//   in_data    in   WIDTH data entering stage 0
//   inv_mask   in   WIDTH per-bit invert select, applied at stage 0 only
//   out_valid  out  valid flag of the last stage
//   out_data   out  WIDTH data of the last stage (registered)
//   occupancy  out  CNT_W number of stages holding valid data
module polarity_pipe
  import polarity_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] inv_mask,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
);

  // Parameter legality is rejected at elaboration.
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("polarity_pipe: WIDTH=%0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
  end
  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("polarity_pipe: DEPTH=%0d outside %0d..%0d", DEPTH, DEPTH_MIN, DEPTH_MAX);
  end
  if (CNT_W < cnt_width(DEPTH)) begin : g_bad_cnt_w
    $error("polarity_pipe: CNT_W=%0d too narrow for DEPTH=%0d", CNT_W, DEPTH);
  end

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] stage0_data;
  logic [CNT_W-1:0] occ_q;

  // The mask is folded in before stage 0, so later mask changes never touch
  // data already in flight.
  assign stage0_data = in_data ^ inv_mask;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             d_valid;
    logic [WIDTH-1:0] d_data;

    if (k == 0) begin : g_head
      assign d_valid = in_valid;
      assign d_data  = stage0_data;
    end else begin : g_link
      assign d_valid = valid_q[k-1];
      assign d_data  = data_q[k-1];
    end

    polarity_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .flush   (flush),
      .d_valid (d_valid),
      .d_data  (d_data),
      .q_valid (valid_q[k]),
      .q_data  (data_q[k])
    );
  end

  // Occupancy tracks entries in minus exits out; an exit is the last stage's
  // valid flag sampled before the edge. Entry and exit together cancel, so the
  // count always equals the number of set valid flags and cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else if (flush) begin
      occ_q <= '0;
    end else if (en) begin
      occ_q <= occ_q + CNT_W'(in_valid) - CNT_W'(valid_q[DEPTH-1]);
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign occupancy = occ_q;

`ifdef SVA
  // rst_gap is high from any reset assertion until the next clock edge, so
  // checks that look back one cycle skip edges whose history was wiped by an
  // asynchronous reset pulse between edges.
  logic rst_gap;
  logic fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_gap <= 1'b1;
    end else begin
      rst_gap <= 1'b0;
    end
  end

  assign fire = en && !flush;

  a_head_capture: assert property (@(posedge clk) disable iff (!rst_n)
    (!rst_gap && $past(fire)) |->
      (valid_q[0] == $past(in_valid)) && (data_q[0] == $past(stage0_data)));

  for (genvar k = 1; k < DEPTH; k++) begin : g_sva_link
    a_link_shift: assert property (@(posedge clk) disable iff (!rst_n)
      (!rst_gap && $past(fire)) |->
        (valid_q[k] == $past(valid_q[k-1])) && (data_q[k] == $past(data_q[k-1])));
  end

  a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n)
    (int'(occupancy) <= DEPTH) && (int'(occupancy) == $countones(valid_q)));

  a_flush_clear: assert property (@(posedge clk) disable iff (!rst_n)
    (!rst_gap && $past(flush)) |->
      (occupancy == '0) && !out_valid && (out_data == '0) && (valid_q == '0));

  a_reset_out_valid: assert property (@(posedge clk)
    !rst_n |-> !out_valid);
`endif

endmodule

// File: tb/tb_polarity_pipe.sv
// tb_polarity_pipe
//   Self-checking bench for polarity_pipe. Three instances (DEPTH 1, 3, 4,
//   WIDTH 8) share one stimulus stream. The reference model is a history list
//   of accepted stage-0 words (newest first): a stage k holds the word pushed
//   k enabled edges ago, flush/reset empties the history. Directed sections
//   pin literal values; a randomized section follows.
module tb_polarity_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [7:0] inv_mask = 8'h00;

  logic       v1, v3, v4;
  logic [7:0] d1, d3, d4;
  logic [0:0] o1;
  logic [1:0] o3;
  logic [2:0] o4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  polarity_pipe #(.WIDTH(8), .DEPTH(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(in_valid),
    .in_data(in_data), .inv_mask(inv_mask), .out_valid(v1), .out_data(d1),
    .occupancy(o1));

  polarity_pipe #(.WIDTH(8), .DEPTH(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(in_valid),
    .in_data(in_data), .inv_mask(inv_mask), .out_valid(v3), .out_data(d3),
    .occupancy(o3));

  polarity_pipe #(.WIDTH(8), .DEPTH(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(in_valid),
    .in_data(in_data), .inv_mask(inv_mask), .out_valid(v4), .out_data(d4),
    .occupancy(o4));

  // Reference model: accepted words, newest at index 0.
  typedef struct packed {
    logic       v;
    logic [7:0] d;
  } ent_t;

  ent_t hist[$];

  always @(negedge rst_n) hist.delete();

  always @(posedge clk) begin
    if (!rst_n || flush) begin
      hist.delete();
    end else if (en) begin
      hist.push_front({in_valid, in_data ^ inv_mask});
      if (hist.size() > 8) void'(hist.pop_back());
    end
  end

  function automatic ent_t at(input int i);
    ent_t e;
    e = '0;
    if (i < hist.size()) e = hist[i];
    return e;
  endfunction

  function automatic int occ_of(input int depth);
    int   n;
    ent_t e;
    n = 0;
    for (int i = 0; i < depth; i++) begin
      e = at(i);
      n += int'(e.v);
    end
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk) begin
    ent_t e;
    e = at(0);
    chk("d1 out_valid", int'(v1), int'(e.v));
    chk("d1 out_data",  int'(d1), int'(e.d));
    chk("d1 occupancy", int'(o1), occ_of(1));
    e = at(2);
    chk("d3 out_valid", int'(v3), int'(e.v));
    chk("d3 out_data",  int'(d3), int'(e.d));
    chk("d3 occupancy", int'(o3), occ_of(3));
    e = at(3);
    chk("d4 out_valid", int'(v4), int'(e.v));
    chk("d4 out_data",  int'(d4), int'(e.d));
    chk("d4 occupancy", int'(o4), occ_of(4));
  end

  // Advance to 2 time units after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int occ_up[6];
    int occ_down[4];
    occ_up   = '{1, 2, 3, 4, 4, 4};
    occ_down = '{3, 2, 1, 0};

    // Reset state
    rst_n = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    chk("reset d3 out_valid", int'(v3), 0);
    chk("reset d3 out_data",  int'(d3), 0);
    chk("reset d3 occupancy", int'(o3), 0);
    chk("reset d1 out_valid", int'(v1), 0);

    // DEPTH=1 full inversion: 5A -> A5 one cycle later
    en = 1'b1; inv_mask = 8'hFF; in_data = 8'h5A; in_valid = 1'b1;
    cyc();
    chk("single-flop out_data",  int'(d1), 'hA5);
    chk("single-flop out_valid", int'(v1), 1);
    chk("single-flop occupancy", int'(o1), 1);
    in_valid = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0;

    // Mask applied at entry only
    inv_mask = 8'h0F; in_data = 8'h01; in_valid = 1'b1;
    cyc();
    inv_mask = 8'h00; in_data = 8'h02;
    cyc();
    in_data = 8'h03;
    cyc();
    chk("mask first out",  int'(d3), 'h0E);
    in_valid = 1'b0;
    cyc();
    chk("mask second out", int'(d3), 'h02);
    cyc();
    chk("mask third out",  int'(d3), 'h03);
    flush = 1'b1;
    cyc();
    flush = 1'b0;

    // Full pipe holds under en=0
    in_valid = 1'b1; in_data = 8'h11; cyc();
    in_data = 8'h22; cyc();
    in_data = 8'h33; cyc();
    chk("full out_data",  int'(d3), 'h11);
    chk("full occupancy", int'(o3), 3);
    en = 1'b0; in_data = 8'hEE; in_valid = 1'b1;
    repeat (4) begin
      cyc();
      chk("hold out_data",  int'(d3), 'h11);
      chk("hold out_valid", int'(v3), 1);
      chk("hold occupancy", int'(o3), 3);
    end
    en = 1'b1; in_valid = 1'b0;
    cyc();
    chk("resume second", int'(d3), 'h22);
    cyc();
    chk("resume third",  int'(d3), 'h33);
    chk("resume occupancy", int'(o3), 1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;

    // Flush beats en and discards the input
    in_valid = 1'b1; in_data = 8'h44; cyc();
    in_data = 8'h55; cyc();
    chk("pre-flush occupancy", int'(o3), 2);
    flush = 1'b1; in_data = 8'h77;
    cyc();
    chk("flush occupancy", int'(o3), 0);
    chk("flush out_valid", int'(v3), 0);
    chk("flush out_data",  int'(d3), 0);
    flush = 1'b0; in_valid = 1'b0;
    repeat (3) begin
      cyc();
      chk("post-flush out_valid", int'(v3), 0);
    end

    // DEPTH=4 occupancy ramp up and drain
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'(i + 1);
      cyc();
      chk("ramp occupancy", int'(o4), occ_up[i]);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("drain occupancy", int'(o4), occ_down[i]);
    end

    // Asynchronous reset between edges
    in_valid = 1'b1; in_data = 8'h66; cyc();
    in_data = 8'h67; cyc();
    rst_n = 1'b0;
    #1;
    chk("async reset d3 out_data",  int'(d3), 0);
    chk("async reset d3 occupancy", int'(o3), 0);
    chk("async reset d1 out_valid", int'(v1), 0);
    chk("async reset d4 occupancy", int'(o4), 0);
    #1;
    rst_n = 1'b1;
    in_data = 8'h5C; in_valid = 1'b1;
    cyc();
    chk("after reset d1 out_data", int'(d1), 'h5C);
    in_valid = 1'b0;
    cyc();
    chk("after reset d3 early", int'(v3), 0);
    cyc();
    chk("after reset d3 out_valid", int'(v3), 1);
    chk("after reset d3 out_data",  int'(d3), 'h5C);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      en       = ($urandom_range(0, 9) < 8);
      flush    = ($urandom_range(0, 19) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = 8'($urandom);
      inv_mask = 8'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      cyc();
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
